// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter: data requester has priority over instruction fetch, and one-cycle read data is routed back to its owner.
// Optional fetch starvation guard is enabled by defining MEM_ARB_STARVE_EN.
module mem_port_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [29:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    input  logic              dm_req,
    input  logic [29:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    input  logic              dm_wren,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_data,
    output logic              sram_wren,
    input  logic [31:0]       sram_q,
    output logic              select,
    output logic              addr_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_IF = 2'd1,
        RD_DM = 2'd2
    } owner_t;

    owner_t state, state_next;
    logic   force_if;
    logic   dm_oor;
    logic   addr_err_q;
    logic   unused_ok;

    // Any address bit above the SRAM index makes a data access out of range.
    assign dm_oor = |dm_addr[29:ADDR_W];

`ifdef MEM_ARB_STARVE_EN
    localparam int                CNT_W        = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;

    assign force_if  = if_req && dm_req && (starve_cnt == STARVE_LIMIT);
    assign unused_ok = ^if_addr[29:ADDR_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            starve_cnt <= '0;
        end else if (dm_gnt) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign force_if  = 1'b0;
    assign unused_ok = ^{if_addr[29:ADDR_W], STARVE_MAX[0]};
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path through the if-tree infers a latch.
        if_gnt     = 1'b0;
        dm_gnt     = 1'b0;
        select     = 1'b0;
        sram_addr  = '0;
        sram_wren  = 1'b0;
        state_next = IDLE;
        if (!rst) begin
            if (dm_req && !force_if) begin
                dm_gnt    = 1'b1;
                sram_addr = dm_addr[ADDR_W-1:0];
                sram_wren = dm_wren && !dm_oor;
                if (!dm_wren) begin
                    state_next = RD_DM;
                end
            end else if (if_req) begin
                if_gnt     = 1'b1;
                select     = 1'b1;
                sram_addr  = if_addr[ADDR_W-1:0];
                state_next = RD_IF;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state      <= IDLE;
            addr_err_q <= 1'b0;
        end else begin
            state      <= state_next;
            addr_err_q <= dm_gnt && dm_oor;
        end
    end

    // Masking with rst drops a pending return the moment reset is applied, not one cycle later.
    assign if_rvalid = !rst && (state == RD_IF);
    assign dm_rvalid = !rst && (state == RD_DM);
    assign addr_err  = !rst && addr_err_q;

    assign sram_data = dm_wdata;
    assign rdata     = sram_q;

endmodule
